// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Slow word-organised data RAM: one request at a time, WAIT_CYCLES wait states,
// then a single-cycle response strobe.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  data_mem_if.slave  bus
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [29:0] idx;
  logic [IdxW-1:0] mem_idx;
  logic        err;
  logic        mem_we;

  always_comb begin
    // Unsigned subtraction may wrap for addresses below the base; the explicit
    // below-base compare catches that case.
    idx     = addr_q[31:2] - BASE_ADDR[31:2];
    mem_idx = idx[IdxW-1:0];
    err     = (addr_q[1:0] != 2'b00) || (addr_q[31:2] < BASE_ADDR[31:2]) ||
              ({2'b00, idx} >= DEPTH_WORDS);

    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_err_d   = err;
        resp_rdata_d = (err || write_q) ? 32'h0 : mem_q[mem_idx];
        mem_we       = write_q && !err;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request latches and storage are not reset; reset only blocks the commit.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (mem_we && !rst) mem_q[mem_idx] <= wdata_q;
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: DUT A uses two wait states, DUT B uses none.
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  data_mem_if ifa ();
  data_mem_if ifb ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
    end else begin
      ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction
  function automatic logic get_rv(input int sel);
    return (sel == 0) ? ifa.resp_valid : ifb.resp_valid;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? ifa.resp_rdata : ifb.resp_rdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? ifa.resp_err : ifb.resp_err;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? ifa.busy : ifb.busy;
  endfunction

  // One full transaction; lat = edges from acceptance to visible resp_valid.
  task automatic xact(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input string tag,
                      output logic [31:0] rd, output logic er);
    int n;
    drive(sel, 1'b1, w, a, d);
    n = 0;
    while (!get_ready(sel) && n < 64) begin
      tick();
      n++;
    end
    tick();
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    check({tag, "_ready_low"}, 32'(get_ready(sel)), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!get_rv(sel) && n < 64);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    rd = get_rdata(sel);
    er = get_err(sel);
    tick();
    check({tag, "_pulse_drop"}, 32'(get_rv(sel)), 32'd0);
  endtask

  logic [31:0] rd, rd1, rd2;
  logic        er, er1, er2;
  int          pulses, e1, e2;
  logic [31:0] hold_addr [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    check("rst_resp_rdata", ifa.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(ifa.resp_err), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_ready", 32'(ifa.req_ready), 32'd1);
    check("rst_busy_b", 32'(ifb.busy), 32'd0);
    rst = 1'b0;

    // Store then load with two wait states
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3, "st10", rd, er);
    check("st10_rdata", rd, 32'h0);
    check("st10_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 3, "ld10", rd, er);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);
    check("ld10_err", 32'(er), 32'd0);

    // Error cases and top-of-range boundary
    xact(0, 1'b1, 32'h0, 32'h0BAD_F00D, 3, "st0", rd, er);
    xact(0, 1'b1, 32'h3FC, 32'hCAFE_0001, 3, "st3fc", rd, er);
    check("st3fc_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h12, 32'h0, 3, "ld12", rd, er);
    check("ld12_err", 32'(er), 32'd1);
    check("ld12_rdata", rd, 32'h0);
    xact(0, 1'b1, 32'h400, 32'h5555_5555, 3, "st400", rd, er);
    check("st400_err", 32'(er), 32'd1);
    check("st400_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h0, 32'h0, 3, "ld0", rd, er);
    check("ld0_rdata", rd, 32'h0BAD_F00D);
    check("ld0_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h3FC, 32'h0, 3, "ld3fc", rd, er);
    check("ld3fc_rdata", rd, 32'hCAFE_0001);
    check("ld3fc_hold", ifa.resp_rdata, 32'hCAFE_0001);

    // Reset during WAIT abandons the store
    xact(0, 1'b1, 32'h20, 32'h1111_2222, 3, "st20", rd, er);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA_5555);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(ifa.busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ifa.resp_valid) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    xact(0, 1'b0, 32'h20, 32'h0, 3, "ld20", rd, er);
    check("ld20_rdata", rd, 32'h1111_2222);

    // Held request with changing address while busy
    hold_addr = '{32'h404, 32'h3, 32'h500, 32'h3FC};
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    pulses = 0;
    e1 = 0;
    e2 = 0;
    rd1 = 32'h0; rd2 = 32'h0; er1 = 1'b0; er2 = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e <= 4) drive(0, 1'b1, 1'b0, hold_addr[e-1], 32'h0);
      else        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      if (ifa.resp_valid) begin
        pulses++;
        if (pulses == 1) begin
          rd1 = ifa.resp_rdata; er1 = ifa.resp_err; e1 = e;
        end else begin
          rd2 = ifa.resp_rdata; er2 = ifa.resp_err; e2 = e;
        end
      end
    end
    check("hold_pulses", 32'(pulses), 32'd2);
    check("hold_first_edge", 32'(e1), 32'd3);
    check("hold_first_rdata", rd1, 32'hDEAD_BEEF);
    check("hold_first_err", 32'(er1), 32'd0);
    check("hold_second_edge", 32'(e2), 32'd7);
    check("hold_second_rdata", rd2, 32'hCAFE_0001);
    check("hold_second_err", 32'(er2), 32'd0);

    // Zero wait states: store, held load accepted two edges later
    drive(1, 1'b1, 1'b1, 32'h4, 32'h1234_5678);
    tick();
    check("w0_st_busy", 32'(ifb.busy), 32'd1);
    check("w0_st_ready", 32'(ifb.req_ready), 32'd0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    check("w0_st_resp", 32'(ifb.resp_valid), 32'd1);
    check("w0_st_err", 32'(ifb.resp_err), 32'd0);
    check("w0_st_rdata", ifb.resp_rdata, 32'h0);
    check("w0_ready_back", 32'(ifb.req_ready), 32'd1);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("w0_ld_accepted", 32'(get_busy(1)), 32'd1);
    check("w0_no_resp_yet", 32'(ifb.resp_valid), 32'd0);
    tick();
    check("w0_ld_resp", 32'(ifb.resp_valid), 32'd1);
    check("w0_ld_rdata", ifb.resp_rdata, 32'h1234_5678);
    tick();
    check("w0_ld_drop", 32'(ifb.resp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
